// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock FIFO.
package fifo_pkg;

  // Occupancy after one cycle, given the effective (already qualified) write and read.
  function automatic int unsigned fifo_next_count(int unsigned count, logic wr_en, logic rd_en);
    if (wr_en && !rd_en) begin
      return count + 1;
    end
    if (rd_en && !wr_en) begin
      return count - 1;
    end
    return count;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage with a registered read port and a write-to-read bypass.
module fifo_ram #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 4
) (
  input  logic              clk_i,
  input  logic              srst_ni,
  input  logic              wr_en_i,
  input  logic [AWIDTH-1:0] wr_addr_i,
  input  logic [DWIDTH-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AWIDTH-1:0] rd_addr_i,
  output logic [DWIDTH-1:0] rd_data_o
);

  localparam int unsigned DEPTH = 2**AWIDTH;

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [DWIDTH-1:0] r_rd_data;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      r_mem[wr_addr_i] <= wr_data_i;
    end
  end

  // A word written this edge to the address being read is forwarded, so a write into an
  // empty FIFO is visible on the output right after the same edge.
  always_ff @(posedge clk_i) begin
    if (!srst_ni) begin
      r_rd_data <= '0;
    end else if (rd_en_i) begin
      if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
        r_rd_data <= wr_data_i;
      end else begin
        r_rd_data <= r_mem[rd_addr_i];
      end
    end
  end

  assign rd_data_o = r_rd_data;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead output, occupancy count and threshold flags.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DWIDTH             = 8,
  parameter int unsigned AWIDTH             = 4,
  parameter int unsigned ALMOST_FULL_VALUE  = 12,
  parameter int unsigned ALMOST_EMPTY_VALUE = 4,
  parameter int unsigned SHOWAHEAD          = 1,
  parameter int unsigned REGISTER_OUTPUT    = 0
) (
  input  logic              clk_i,
  input  logic              srst_ni,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              wrreq_i,
  input  logic              rdreq_i,
  output logic [DWIDTH-1:0] q_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_full_o,
  output logic              almost_empty_o
);

  localparam int unsigned DEPTH = 2**AWIDTH;

  logic [AWIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [AWIDTH-1:0] w_wr_ptr_next, w_rd_ptr_next;
  logic [AWIDTH:0]   r_usedw, w_usedw_next;
  logic              w_wr_en, w_rd_en;
  logic              w_ram_wr_en, w_ram_rd_en;
  logic [AWIDTH-1:0] w_ram_rd_addr;
  logic [DWIDTH-1:0] w_ram_q;

  assign w_wr_en       = wrreq_i & ~full_o;
  assign w_rd_en       = rdreq_i & ~empty_o;
  assign w_wr_ptr_next = w_wr_en ? r_wr_ptr + AWIDTH'(1) : r_wr_ptr;
  assign w_rd_ptr_next = w_rd_en ? r_rd_ptr + AWIDTH'(1) : r_rd_ptr;
  assign w_usedw_next  = (AWIDTH+1)'(fifo_next_count(32'(r_usedw), w_wr_en, w_rd_en));

  always_ff @(posedge clk_i) begin
    if (!srst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usedw  <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
      r_usedw  <= w_usedw_next;
    end
  end

  // Show-ahead prefetches the head for the next cycle and holds when the FIFO goes empty;
  // normal mode fetches the popped word on the read edge.
  assign w_ram_wr_en   = w_wr_en & srst_ni;
  assign w_ram_rd_addr = (SHOWAHEAD != 0) ? w_rd_ptr_next : r_rd_ptr;
  assign w_ram_rd_en   = (SHOWAHEAD != 0) ? (w_usedw_next != '0) : w_rd_en;

  fifo_ram #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_ram (
    .clk_i     (clk_i),
    .srst_ni   (srst_ni),
    .wr_en_i   (w_ram_wr_en),
    .wr_addr_i (r_wr_ptr),
    .wr_data_i (data_i),
    .rd_en_i   (w_ram_rd_en),
    .rd_addr_i (w_ram_rd_addr),
    .rd_data_o (w_ram_q)
  );

  generate
    if (REGISTER_OUTPUT != 0) begin : g_out_reg
      logic [DWIDTH-1:0] r_q;
      always_ff @(posedge clk_i) begin
        if (!srst_ni) begin
          r_q <= '0;
        end else begin
          r_q <= w_ram_q;
        end
      end
      assign q_o = r_q;
    end else begin : g_out_direct
      assign q_o = w_ram_q;
    end
  endgenerate

  assign usedw_o        = r_usedw;
  assign empty_o        = (r_usedw == '0);
  assign full_o         = (32'(r_usedw) == DEPTH);
  assign almost_full_o  = (32'(r_usedw) >= ALMOST_FULL_VALUE);
  assign almost_empty_o = (32'(r_usedw) < ALMOST_EMPTY_VALUE);

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised scoreboard bench for sync_fifo against a queue-based reference model.
module tb_sync_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AFV   = 12;
  localparam int unsigned AEV   = 4;

  logic          clk = 1'b0;
  logic          srst_n = 1'b0;
  logic          wrreq = 1'b0;
  logic          rdreq = 1'b0;
  logic [DW-1:0] data = '0;
  logic [DW-1:0] q;
  logic [AW:0]   usedw;
  logic          empty, full, afull, aempty;

  always #5 clk = ~clk;

  sync_fifo #(
    .DWIDTH             (DW),
    .AWIDTH             (AW),
    .ALMOST_FULL_VALUE  (AFV),
    .ALMOST_EMPTY_VALUE (AEV),
    .SHOWAHEAD          (1),
    .REGISTER_OUTPUT    (0)
  ) dut (
    .clk_i          (clk),
    .srst_ni        (srst_n),
    .data_i         (data),
    .wrreq_i        (wrreq),
    .rdreq_i        (rdreq),
    .q_o            (q),
    .usedw_o        (usedw),
    .empty_o        (empty),
    .full_o         (full),
    .almost_full_o  (afull),
    .almost_empty_o (aempty)
  );

  typedef struct {
    logic [DW-1:0] q;
    int            usedw;
    bit            empty;
    bit            full;
    bit            afull;
    bit            aempty;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] mdl[$];
  logic [DW-1:0] mdl_head = '0;
  exp_t          mon_e;
  int            n_cmp = 0;
  int            n_fail = 0;

  task automatic chk(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Apply one cycle of stimulus and push what the outputs must show after the edge.
  task automatic step(bit rst, bit wr, bit rd, logic [DW-1:0] d);
    exp_t e;
    bit   do_wr;
    bit   do_rd;
    @(negedge clk);
    srst_n = ~rst;
    wrreq  = wr;
    rdreq  = rd;
    data   = d;
    if (rst) begin
      mdl.delete();
      mdl_head = '0;
    end else begin
      do_rd = rd && (mdl.size() != 0);
      do_wr = wr && (mdl.size() != DEPTH);
      if (do_rd) void'(mdl.pop_front());
      if (do_wr) mdl.push_back(d);
      if (mdl.size() != 0) mdl_head = mdl[0];
    end
    e.q      = mdl_head;
    e.usedw  = mdl.size();
    e.empty  = (mdl.size() == 0);
    e.full   = (mdl.size() == DEPTH);
    e.afull  = (mdl.size() >= AFV);
    e.aempty = (mdl.size() < AEV);
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("q_o", int'(q), int'(mon_e.q));
      chk("usedw_o", int'(usedw), mon_e.usedw);
      chk("empty_o", int'(empty), int'(mon_e.empty));
      chk("full_o", int'(full), int'(mon_e.full));
      chk("almost_full_o", int'(afull), int'(mon_e.afull));
      chk("almost_empty_o", int'(aempty), int'(mon_e.aempty));
    end
  end

  initial begin
    step(1, 0, 0, 8'h00);
    step(1, 1, 1, 8'h33);
    repeat (16) step(0, 0, 1, 8'h00);
    for (int i = 0; i < 20; i++) step(0, 1, 0, DW'(i));
    repeat (20) step(0, 0, 1, 8'h00);
    step(0, 1, 0, 8'hA5);
    step(0, 0, 0, 8'h00);
    step(0, 0, 1, 8'h00);
    // Concurrent traffic at 5, at full and at empty.
    for (int i = 0; i < 5; i++) step(0, 1, 0, DW'($urandom));
    repeat (3) step(0, 1, 1, DW'($urandom));
    for (int i = 0; i < 11; i++) step(0, 1, 0, DW'($urandom));
    step(0, 1, 1, 8'hEE);
    repeat (15) step(0, 0, 1, 8'h00);
    step(0, 1, 1, 8'h5A);
    step(0, 0, 1, 8'h00);
    for (int i = 0; i < 1000; i++) begin
      step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom));
    end
    // Reset in mid-operation discards contents.
    for (int i = 0; i < 6; i++) step(0, 1, 0, DW'($urandom));
    step(1, 1, 1, 8'h77);
    repeat (3) step(0, 0, 1, 8'h00);
    step(0, 1, 0, 8'h3C);
    step(0, 0, 1, 8'h00);
    @(negedge clk);
    wrreq = 1'b0;
    rdreq = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
